// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: computes A - B - bin one DIGIT-bit slice per clock,
// carrying the borrow between slices in a register, and presents the result in DONE.
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero,
   output logic             busy,
   output logic             valid
);

   localparam int NSLICE = WIDTH / DIGIT;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Handshake: start is accepted on a rising edge only while IDLE or DONE;
   // valid stays high in DONE until the next accepted start or reset.
   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             brw_q, brw_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;

   logic [DIGIT-1:0] slice_a, slice_b, slice_d;
   logic [DIGIT:0]   chain;
   logic [WIDTH-1:0] merged;

   // Slice datapath: select the slice under the counter and ripple the borrow.
   always_comb begin
      slice_a = '0;
      slice_b = '0;
      for (int s = 0; s < NSLICE; s++) begin
         if (cnt_q == CW'(s)) begin
            slice_a = a_q[s*DIGIT +: DIGIT];
            slice_b = b_q[s*DIGIT +: DIGIT];
         end
      end
      chain    = '0;
      slice_d  = '0;
      chain[0] = brw_q;
      for (int i = 0; i < DIGIT; i++) begin
         slice_d[i]   = slice_a[i] ^ slice_b[i] ^ chain[i];
         chain[i + 1] = (~slice_a[i] & slice_b[i]) | (~slice_a[i] & chain[i])
                      | (slice_b[i] & chain[i]);
      end
      merged = acc_q;
      for (int s = 0; s < NSLICE; s++) begin
         if (cnt_q == CW'(s)) begin
            merged[s*DIGIT +: DIGIT] = slice_d;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      brw_d   = brw_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               brw_d   = bin;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            acc_d = merged;
            brw_d = chain[DIGIT];
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Top slice: borrow into and out of the MSB give signed overflow.
               diff_d  = merged;
               bout_d  = chain[DIGIT];
               ovf_d   = chain[DIGIT-1] ^ chain[DIGIT];
               zero_d  = (merged == '0);
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d  = (state_d == RUN);
      valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         brw_q   <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         brw_q   <= brw_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end

   assign diff  = diff_q;
   assign bout  = bout_q;
   assign ovf   = ovf_q;
   assign zero  = zero_q;
   assign busy  = busy_q;
   assign valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor with DIGIT=4, DIGIT=1 and DIGIT=16 instances
// (WIDTH=16) sharing operands, each with its own start and result outputs.
module tb_serial_subtractor;

   logic        clk;
   logic        rst_n;
   logic [2:0]  start_v;
   logic [15:0] a_in, b_in;
   logic        bin_in;
   logic [15:0] diff_w [3];
   logic [2:0]  bout_w, ovf_w, zero_w, busy_w, valid_w;

   logic [18:0] exp_q[$];
   logic [18:0] prev_res [3];
   int          n_checks;
   int          n_pass;

   serial_subtractor #(.WIDTH(16), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .A(a_in), .B(b_in), .bin(bin_in),
      .diff(diff_w[0]), .bout(bout_w[0]), .ovf(ovf_w[0]), .zero(zero_w[0]),
      .busy(busy_w[0]), .valid(valid_w[0]));

   serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .A(a_in), .B(b_in), .bin(bin_in),
      .diff(diff_w[1]), .bout(bout_w[1]), .ovf(ovf_w[1]), .zero(zero_w[1]),
      .busy(busy_w[1]), .valid(valid_w[1]));

   serial_subtractor #(.WIDTH(16), .DIGIT(16)) u_d16 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .A(a_in), .B(b_in), .bin(bin_in),
      .diff(diff_w[2]), .bout(bout_w[2]), .ovf(ovf_w[2]), .zero(zero_w[2]),
      .busy(busy_w[2]), .valid(valid_w[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {diff, bout, ovf, zero} of A - B - bin.
   function automatic logic [18:0] model(logic [15:0] a, logic [15:0] b, logic c);
      logic [16:0] full;
      int          sr;
      logic        v;
      full = {1'b0, a} - {1'b0, b} - {16'd0, c};
      sr   = int'($signed(a)) - int'($signed(b)) - int'(c);
      v    = (sr > 32767) || (sr < -32768);
      return {full[15:0], full[16], v, (full[15:0] == 16'd0)};
   endfunction

   function automatic int nslice(int k);
      return (k == 0) ? 4 : ((k == 1) ? 16 : 1);
   endfunction

   function automatic logic [18:0] observed(int k);
      return {diff_w[k], bout_w[k], ovf_w[k], zero_w[k]};
   endfunction

   // Called at a negedge: present operands, raise start, record expectation.
   task automatic launch(int k, logic [15:0] a, logic [15:0] b, logic c);
      a_in   = a;
      b_in   = b;
      bin_in = c;
      exp_q.push_back(model(a, b, c));
      start_v[k] = 1'b1;
   endtask

   // Waits for the launched operation to complete and scores it.
   task automatic finish_op(int k, bit disturb);
      logic [18:0] exp_v;
      int          lat;
      @(negedge clk);
      start_v[k] = 1'b0;
      n_checks++;
      if (busy_w[k] !== 1'b1 || valid_w[k] !== 1'b0)
         $display("FAIL accept[%0d]: busy=%b valid=%b, required busy=1 valid=0", k, busy_w[k], valid_w[k]);
      else n_pass++;
      lat = 0;
      while (valid_w[k] !== 1'b1 && lat < 64) begin
         n_checks++;
         if (observed(k) !== prev_res[k] || (busy_w[k] & valid_w[k]))
            $display("FAIL hold_in_run[%0d]: got %h busy=%b valid=%b, required %h", k,
                     observed(k), busy_w[k], valid_w[k], prev_res[k]);
         else n_pass++;
         if (disturb) begin
            a_in       = 16'($urandom);
            b_in       = 16'($urandom);
            bin_in     = 1'($urandom_range(0, 1));
            start_v[k] = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      start_v[k] = 1'b0;
      n_checks++;
      if (lat != nslice(k) || busy_w[k] !== 1'b0)
         $display("FAIL latency[%0d]: got %0d clocks busy=%b, required %0d clocks busy=0", k, lat,
                  busy_w[k], nslice(k));
      else n_pass++;
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h0;
      n_checks++;
      if (observed(k) !== exp_v)
         $display("FAIL result[%0d]: got diff/bout/ovf/zero=%h, required %h", k, observed(k), exp_v);
      else n_pass++;
      prev_res[k] = exp_v;
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start_v = '0;
      a_in    = '0;
      b_in    = '0;
      bin_in  = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         prev_res[k] = '0;
         n_checks++;
         if (observed(k) !== 19'h0 || busy_w[k] !== 1'b0 || valid_w[k] !== 1'b0)
            $display("FAIL reset[%0d]: got %h busy=%b valid=%b, required all 0", k, observed(k),
                     busy_w[k], valid_w[k]);
         else n_pass++;
      end
      rst_n = 1'b1;
   endtask

   task automatic test_directed(int k);
      logic [15:0] va [6] = '{16'h1234, 16'h0000, 16'h8000, 16'h0005, 16'h0000, 16'h7FFF};
      logic [15:0] vb [6] = '{16'h0234, 16'h0001, 16'h0001, 16'h0004, 16'hFFFF, 16'hFFFF};
      logic        vc [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         launch(k, va[i], vb[i], vc[i]);
         finish_op(k, 1'b0);
      end
   endtask

   task automatic test_done_hold();
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (observed(0) !== prev_res[0] || valid_w[0] !== 1'b1 || busy_w[0] !== 1'b0)
            $display("FAIL done_hold: got %h valid=%b busy=%b, required %h valid=1 busy=0",
                     observed(0), valid_w[0], busy_w[0], prev_res[0]);
         else n_pass++;
      end
   endtask

   task automatic test_ignore_in_run(int k);
      @(negedge clk);
      launch(k, 16'hA5C3, 16'h3C5A, 1'b1);
      finish_op(k, 1'b1);
   endtask

   task automatic test_back_to_back(int k);
      @(negedge clk);
      launch(k, 16'h1234, 16'h0234, 1'b0);
      finish_op(k, 1'b0);
      launch(k, 16'h0000, 16'h0001, 1'b0);
      finish_op(k, 1'b0);
      launch(k, 16'h8000, 16'h0001, 1'b0);
      finish_op(k, 1'b0);
      launch(k, 16'h0005, 16'h0004, 1'b1);
      finish_op(k, 1'b0);
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      launch(0, 16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (observed(0) !== 19'h0 || busy_w[0] !== 1'b0 || valid_w[0] !== 1'b0)
         $display("FAIL mid_reset: got %h busy=%b valid=%b, required all 0", observed(0),
                  busy_w[0], valid_w[0]);
      else n_pass++;
      void'(exp_q.pop_front());
      for (int k = 0; k < 3; k++) prev_res[k] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      launch(0, 16'h1234, 16'h0234, 1'b0);
      finish_op(0, 1'b0);
   endtask

   task automatic test_random(int k, int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 0) @(negedge clk);
         launch(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
         finish_op(k, ($urandom_range(0, 3) == 0));
      end
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      test_reset();
      for (int k = 0; k < 3; k++) test_directed(k);
      test_done_hold();
      test_ignore_in_run(0);
      test_ignore_in_run(1);
      test_back_to_back(0);
      test_back_to_back(2);
      test_mid_reset();
      test_random(0, 6000);
      test_random(2, 4000);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4: bits processed per clock; SHALL evenly divide WIDTH and be >= 1.
REQ-003 The clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 Port list SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- A  input  WIDTH  minuend; sampled with accepted start
- B  input  WIDTH  subtrahend; sampled with accepted start
- bin  input  1  borrow-in; sampled with accepted start
- diff  output  WIDTH  registered result of A - B - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out; 1 iff A < B + bin as unsigned values
- ovf  output  1  signed overflow (two's-complement)
- zero  output  1  1 iff diff == 0
- busy  output  1  high in RUN
- valid  output  1  high in DONE; diff, bout, ovf and zero are meaningful

Function
REQ-005 FSM SHALL have three states: IDLE, RUN, DONE.
REQ-006 IDLE, start=1: latch A, B and bin; clear digit counter; go to RUN. IDLE, start=0: stay in IDLE.
REQ-007 RUN: each clock SHALL subtract the lowest unprocessed DIGIT-bit slice with a ripple borrow chain. The chain SHALL use per-bit difference a^b^borrow. The chain SHALL use per-bit borrow (~a&b)|(~a&borrow)|(b&borrow).
REQ-008 Borrow out of each slice SHALL be registered and used as the borrow-in of the next slice. The first slice SHALL use the latched bin.
REQ-009 RUN SHALL last exactly WIDTH/DIGIT clocks. On the last RUN clock, the FSM SHALL load diff, bout, ovf and zero and go to DONE.
- Latency: valid rises WIDTH/DIGIT clocks after the edge that accepted start.
REQ-010 ovf SHALL equal (borrow into bit WIDTH-1) XOR (borrow out of bit WIDTH-1).
REQ-011 diff, bout, ovf and zero SHALL hold their previous values throughout RUN. Partial results SHALL never appear on them.
REQ-012 start SHALL be ignored in RUN. Operands latched at acceptance SHALL be unaffected by later changes to A, B and bin.
REQ-013 DONE, start=0: hold all outputs with valid=1.
REQ-014 DONE, start=1: latch new operands, go to RUN and drop valid on the same edge, giving back-to-back operation.
REQ-015 busy and valid SHALL never be high at the same time.
REQ-016 DIGIT == WIDTH SHALL be legal: single-clock RUN, latency 1.

Reset
REQ-017 rst_n=0 SHALL force IDLE immediately, independent of clk.
REQ-018 Reset values: diff=0, bout=0, ovf=0, zero=0, busy=0, valid=0. Internal operand, borrow and counter registers SHALL also reset to 0.
REQ-019 Reset asserted mid-RUN SHALL abandon the operation; no result is produced.
REQ-020 After rst_n deasserts, the first accepted start SHALL behave as from power-up.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-021 A=0x1234, B=0x0234, bin=0 -> 4 clocks later: valid=1, diff=0x1000, bout=0, ovf=0, zero=0.
REQ-022 A=0x0000, B=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. A=0x8000, B=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
REQ-023 A=0x0005, B=0x0004, bin=1 -> diff=0x0000, zero=1, bout=0. The borrow-in path SHALL be exercised.
REQ-024 Start pulse and operand changes in RUN -> ignored, result matches the original operands. A start on the valid cycle -> valid drops the next edge and the new result arrives 4 clocks later.
REQ-025 rst_n pulsed low on RUN clock 2 -> all outputs 0 immediately, FSM in IDLE; a subsequent operation is correct.
REQ-026 Repeat REQ-021 to REQ-023 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) -> identical results. Also run 10k random operands against the reference model A - B - bin.
